// File: rtl/mask_frame_scanner.sv
// rtl/mask_frame_scanner.sv - raster scan of a 1-bit mask BRAM into an (x, y, valid) stream with end-of-frame tabulate.
// Optional: define MASK_SCANNER_MIN_PIXELS_EN to suppress tabulate_out on frames with fewer than MIN_PIXELS set pixels.
module mask_frame_scanner #(
    parameter int H_ACTIVE   = 1280,
    parameter int V_ACTIVE   = 720,
    parameter int ADDR_W     = 20,
    parameter int RD_LAT     = 2,
    parameter int MIN_PIXELS = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    output logic [ADDR_W-1:0] mask_addr_out,
    output logic              mask_rd_out,
    input  logic              mask_data_in,
    output logic [10:0]       x_out,
    output logic [9:0]        y_out,
    output logic              valid_out,
    output logic              tabulate_out,
    output logic              busy_out,
    output logic [20:0]       pixel_count_out,
    output logic              done_out
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, TAB} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [10:0]       X_LAST     = 11'(H_ACTIVE - 1);
    localparam logic [7:0]        DRAIN_LAST = 8'(RD_LAT - 1);

`ifdef MASK_SCANNER_MIN_PIXELS_EN
    localparam logic [20:0] MIN_CNT = 21'(MIN_PIXELS);
`else
    logic unused_min_pixels;
    assign unused_min_pixels = (MIN_PIXELS != 0);
`endif

    state_t      state;
    logic [10:0] x_cnt;
    logic [9:0]  y_cnt;
    logic [7:0]  drain_cnt;
    logic [20:0] run_count;

    // Issued coordinates ride alongside the outstanding BRAM reads.
    logic [10:0] pipe_x  [RD_LAT];
    logic [9:0]  pipe_y  [RD_LAT];
    logic        pipe_rd [RD_LAT];

    logic hit;
    assign hit = pipe_rd[RD_LAT-1] & mask_data_in;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state           <= IDLE;
            x_cnt           <= '0;
            y_cnt           <= '0;
            drain_cnt       <= '0;
            run_count       <= '0;
            mask_addr_out   <= '0;
            mask_rd_out     <= 1'b0;
            x_out           <= '0;
            y_out           <= '0;
            valid_out       <= 1'b0;
            tabulate_out    <= 1'b0;
            busy_out        <= 1'b0;
            pixel_count_out <= '0;
            done_out        <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_x[i]  <= '0;
                pipe_y[i]  <= '0;
                pipe_rd[i] <= 1'b0;
            end
        end else begin
            pipe_x[0]  <= x_cnt;
            pipe_y[0]  <= y_cnt;
            pipe_rd[0] <= mask_rd_out;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_x[i]  <= pipe_x[i-1];
                pipe_y[i]  <= pipe_y[i-1];
                pipe_rd[i] <= pipe_rd[i-1];
            end

            x_out     <= pipe_x[RD_LAT-1];
            y_out     <= pipe_y[RD_LAT-1];
            valid_out <= hit;
            if (hit && (run_count != '1))
                run_count <= run_count + 1'b1;

            tabulate_out <= 1'b0;
            done_out     <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_in) begin
                        state         <= SCAN;
                        busy_out      <= 1'b1;
                        mask_rd_out   <= 1'b1;
                        mask_addr_out <= '0;
                        x_cnt         <= '0;
                        y_cnt         <= '0;
                        run_count     <= '0;
                    end
                end
                SCAN: begin
                    if (mask_addr_out == LAST_ADDR) begin
                        state       <= DRAIN;
                        mask_rd_out <= 1'b0;
                        drain_cnt   <= '0;
                    end else begin
                        mask_addr_out <= mask_addr_out + 1'b1;
                        if (x_cnt == X_LAST) begin
                            x_cnt <= '0;
                            y_cnt <= y_cnt + 1'b1;
                        end else begin
                            x_cnt <= x_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // The last read's hit is counted on the final DRAIN cycle, so TAB sees the full count.
                    if (drain_cnt == DRAIN_LAST)
                        state <= TAB;
                    else
                        drain_cnt <= drain_cnt + 1'b1;
                end
                TAB: begin
                    state           <= IDLE;
                    busy_out        <= 1'b0;
                    done_out        <= 1'b1;
                    pixel_count_out <= run_count;
`ifdef MASK_SCANNER_MIN_PIXELS_EN
                    tabulate_out    <= (run_count >= MIN_CNT);
`else
                    tabulate_out    <= 1'b1;
`endif
                end
                default: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mask_frame_scanner.sv
// tb/tb_mask_frame_scanner.sv - directed self-checking bench for mask_frame_scanner on a 4x3 frame.
module tb_mask_frame_scanner;

    localparam int H    = 4;
    localparam int V    = 3;
    localparam int AW   = 4;
    localparam int LAT  = 2;
    localparam int MINP = 4;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          start_in;
    logic [AW-1:0] mask_addr_out;
    logic          mask_rd_out;
    logic          mask_data_in;
    logic [10:0]   x_out;
    logic [9:0]    y_out;
    logic          valid_out;
    logic          tabulate_out;
    logic          busy_out;
    logic [20:0]   pixel_count_out;
    logic          done_out;

    always #5 clk_in = ~clk_in;

    mask_frame_scanner #(
        .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .RD_LAT(LAT), .MIN_PIXELS(MINP)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .start_in(start_in),
        .mask_addr_out(mask_addr_out),
        .mask_rd_out(mask_rd_out),
        .mask_data_in(mask_data_in),
        .x_out(x_out),
        .y_out(y_out),
        .valid_out(valid_out),
        .tabulate_out(tabulate_out),
        .busy_out(busy_out),
        .pixel_count_out(pixel_count_out),
        .done_out(done_out)
    );

    // Two-cycle-latency BRAM model
    logic mem [16];
    logic bram_d1 = 1'b0;
    logic bram_d2 = 1'b0;
    always @(posedge clk_in) begin
        bram_d1 <= mask_rd_out ? mem[mask_addr_out] : 1'b0;
        bram_d2 <= bram_d1;
    end
    assign mask_data_in = bram_d2;

    int checks   = 0;
    int failures = 0;

    int n_addr, n_valid, n_tab, n_done, tab_cyc, overlap, count_at_done;
    int addr_log [64];
    int addr_cyc [64];
    int vx       [64];
    int vy       [64];
    int vcyc     [64];

    task automatic set_mask(input logic [15:0] bits);
        for (int i = 0; i < 16; i++) mem[i] = bits[i];
    endtask

    // Observes one frame starting at the first negedge after start_in is sampled.
    task automatic collect(input int restart_at, input int budget);
        int after;
        n_addr = 0; n_valid = 0; n_tab = 0; n_done = 0;
        tab_cyc = -1; overlap = 0; count_at_done = -1; after = 0;
        for (int cyc = 0; cyc < budget && after < 4; cyc++) begin
            @(negedge clk_in);
            if (mask_rd_out && n_addr < 64) begin
                addr_log[n_addr] = int'(mask_addr_out);
                addr_cyc[n_addr] = cyc;
                n_addr++;
            end
            if (valid_out && n_valid < 64) begin
                vx[n_valid]   = int'(x_out);
                vy[n_valid]   = int'(y_out);
                vcyc[n_valid] = cyc;
                n_valid++;
            end
            if (tabulate_out) begin
                n_tab++;
                tab_cyc = cyc;
                if (valid_out) overlap = 1;
            end
            if (done_out) begin
                n_done++;
                count_at_done = int'(pixel_count_out);
            end
            if (n_done > 0) after++;
            start_in = (cyc == restart_at);
        end
        start_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b0; start_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if ({mask_addr_out, mask_rd_out, x_out, y_out, valid_out, tabulate_out,
             busy_out, pixel_count_out, done_out} !== 51'd0) begin
            failures++;
            $display("FAIL reset_outputs got addr=%0d rd=%0b x=%0d y=%0d v=%0b tab=%0b busy=%0b cnt=%0d done=%0b want all 0",
                     mask_addr_out, mask_rd_out, x_out, y_out, valid_out, tabulate_out, busy_out, pixel_count_out, done_out);
        end
        repeat (3) @(negedge clk_in);
        checks++;
        if (busy_out !== 1'b0 || mask_rd_out !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_start got busy=%0b rd=%0b want 0 0", busy_out, mask_rd_out);
        end
    endtask

    task automatic test_checkerboard();
        int ex [6] = '{0, 2, 0, 2, 0, 2};
        int ey [6] = '{0, 0, 1, 1, 2, 2};
        int ec [6] = '{3, 5, 7, 9, 11, 13};
        set_mask(16'h0555);
        @(negedge clk_in); start_in = 1'b1;
        collect(-1, 60);
        checks++;
        if (n_addr !== 12) begin
            failures++; $display("FAIL cb_addr_count got %0d want 12", n_addr);
        end
        for (int i = 0; i < 12 && i < n_addr; i++) begin
            checks++;
            if (addr_log[i] !== i || addr_cyc[i] !== i) begin
                failures++;
                $display("FAIL cb_addr_%0d got addr=%0d cyc=%0d want addr=%0d cyc=%0d", i, addr_log[i], addr_cyc[i], i, i);
            end
        end
        checks++;
        if (n_valid !== 6) begin
            failures++; $display("FAIL cb_valid_count got %0d want 6", n_valid);
        end
        for (int i = 0; i < 6 && i < n_valid; i++) begin
            checks++;
            if (vx[i] !== ex[i] || vy[i] !== ey[i] || vcyc[i] !== ec[i]) begin
                failures++;
                $display("FAIL cb_pixel_%0d got (%0d,%0d)@%0d want (%0d,%0d)@%0d", i, vx[i], vy[i], vcyc[i], ex[i], ey[i], ec[i]);
            end
        end
        checks++;
        if (n_tab !== 1 || tab_cyc !== 15 || overlap !== 0) begin
            failures++;
            $display("FAIL cb_tabulate got n=%0d cyc=%0d overlap=%0d want n=1 cyc=15 overlap=0", n_tab, tab_cyc, overlap);
        end
        checks++;
        if (n_done !== 1 || count_at_done !== 6) begin
            failures++;
            $display("FAIL cb_done_count got done=%0d count=%0d want done=1 count=6", n_done, count_at_done);
        end
    endtask

    task automatic test_empty();
        set_mask(16'h0000);
        @(negedge clk_in); start_in = 1'b1;
        collect(-1, 60);
        checks++;
        if (n_valid !== 0) begin
            failures++; $display("FAIL empty_valid got %0d want 0", n_valid);
        end
        checks++;
        if (n_tab !== 1 || n_done !== 1 || count_at_done !== 0) begin
            failures++;
            $display("FAIL empty_tab got tab=%0d done=%0d count=%0d want 1 1 0", n_tab, n_done, count_at_done);
        end
    endtask

    task automatic test_restart_ignored();
        set_mask(16'h0555);
        @(negedge clk_in); start_in = 1'b1;
        collect(5, 60);
        checks++;
        if (n_addr !== 12 || n_tab !== 1 || n_done !== 1) begin
            failures++;
            $display("FAIL restart_ignored got addrs=%0d tab=%0d done=%0d want 12 1 1", n_addr, n_tab, n_done);
        end
    endtask

    task automatic test_back_to_back();
        int waited;
        set_mask(16'h0555);
        @(negedge clk_in); start_in = 1'b1;
        @(negedge clk_in); start_in = 1'b0;
        waited = 0;
        while (done_out !== 1'b1 && waited < 60) begin
            @(negedge clk_in); waited++;
        end
        checks++;
        if (done_out !== 1'b1) begin
            failures++; $display("FAIL bb_first_done got timeout after %0d cycles want done_out", waited);
        end
        @(negedge clk_in); start_in = 1'b1;
        collect(-1, 60);
        checks++;
        if (n_addr < 1 || addr_log[0] !== 0 || addr_cyc[0] !== 0) begin
            failures++;
            $display("FAIL bb_restart got addrs=%0d first_cyc=%0d want scan starting at cyc 0", n_addr, (n_addr > 0) ? addr_cyc[0] : -1);
        end
        checks++;
        if (n_addr !== 12 || n_tab !== 1 || count_at_done !== 6) begin
            failures++;
            $display("FAIL bb_second_frame got addrs=%0d tab=%0d count=%0d want 12 1 6", n_addr, n_tab, count_at_done);
        end
    endtask

    task automatic test_reset_mid_scan();
        int waited, tabs, rds, vals;
        set_mask(16'hFFFF);
        @(negedge clk_in); start_in = 1'b1;
        @(negedge clk_in); start_in = 1'b0;
        waited = 0;
        while (!(mask_rd_out === 1'b1 && mask_addr_out === 4'd7) && waited < 40) begin
            @(negedge clk_in); waited++;
        end
        checks++;
        if (!(mask_rd_out === 1'b1 && mask_addr_out === 4'd7)) begin
            failures++; $display("FAIL mid_reach_addr7 got addr=%0d rd=%0b want 7 1", mask_addr_out, mask_rd_out);
        end
        rst_in = 1'b0;
        @(negedge clk_in);
        checks++;
        if ({mask_addr_out, mask_rd_out, x_out, y_out, valid_out, tabulate_out,
             busy_out, pixel_count_out, done_out} !== 51'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs got addr=%0d rd=%0b v=%0b tab=%0b busy=%0b cnt=%0d done=%0b want all 0",
                     mask_addr_out, mask_rd_out, valid_out, tabulate_out, busy_out, pixel_count_out, done_out);
        end
        rst_in = 1'b1;
        tabs = 0; rds = 0; vals = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (tabulate_out || done_out) tabs++;
            if (mask_rd_out || busy_out) rds++;
            if (valid_out) vals++;
        end
        checks++;
        if (tabs !== 0 || rds !== 0 || vals !== 0) begin
            failures++;
            $display("FAIL mid_after_reset got tab_or_done=%0d busy_or_rd=%0d valid=%0d want 0 0 0", tabs, rds, vals);
        end
    endtask

    task automatic test_min_pixels();
        int exp_tab3;
`ifdef MASK_SCANNER_MIN_PIXELS_EN
        exp_tab3 = 0;
`else
        exp_tab3 = 1;
`endif
        set_mask(16'h0822);
        @(negedge clk_in); start_in = 1'b1;
        collect(-1, 60);
        checks++;
        if (n_done !== 1 || count_at_done !== 3 || n_tab !== exp_tab3) begin
            failures++;
            $display("FAIL min3 got done=%0d count=%0d tab=%0d want 1 3 %0d", n_done, count_at_done, n_tab, exp_tab3);
        end
        set_mask(16'h0A22);
        @(negedge clk_in); start_in = 1'b1;
        collect(-1, 60);
        checks++;
        if (n_done !== 1 || count_at_done !== 4 || n_tab !== 1) begin
            failures++;
            $display("FAIL min4 got done=%0d count=%0d tab=%0d want 1 4 1", n_done, count_at_done, n_tab);
        end
        checks++;
        if (n_valid !== 4 || vx[3] !== 3 || vy[3] !== 2 || vcyc[3] !== 14 || overlap !== 0) begin
            failures++;
            $display("FAIL min4_last_pixel got n=%0d (%0d,%0d)@%0d overlap=%0d want 4 (3,2)@14 0",
                     n_valid, vx[3], vy[3], vcyc[3], overlap);
        end
    endtask

    initial begin
        rst_in   = 1'b0;
        start_in = 1'b0;
        set_mask(16'h0000);
        test_reset();
        test_checkerboard();
        test_empty();
        test_restart_ignored();
        test_back_to_back();
        test_reset_mid_scan();
        test_min_pixels();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
